// File: rtl/clk_div_multi_if.sv
// Control and output bundle of the multi-channel clock divider.
// The master side drives enables, ratios and the sync pulse; the slave side is the divider itself.
interface clk_div_multi_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]       i_clk_en;
    logic [NUM_CH*WIDTH-1:0] i_div_ratio;
    logic                    i_sync;
    logic [NUM_CH-1:0]       o_div_clk;
    logic [NUM_CH-1:0]       o_tick;

    modport master (
        output i_clk_en,
        output i_div_ratio,
        output i_sync,
        input  o_div_clk,
        input  o_tick
    );

    modport slave (
        input  i_clk_en,
        input  i_div_ratio,
        input  i_sync,
        output o_div_clk,
        output o_tick
    );
endinterface

// File: rtl/clk_div_multi.sv
// NUM_CH independent integer dividers of one reference clock. Each channel latches its ratio
// only at period start, so ratio changes and disables never produce runt pulses.
module clk_div_multi #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4
) (
    input  logic          i_clk_ref,
    input  logic          i_rst,
    clk_div_multi_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BYPASS = 2'd2
    } ch_state_t;

    typedef enum logic [2:0] {
        ACT_HOLD   = 3'd0,
        ACT_RELOAD = 3'd1,
        ACT_COUNT  = 3'd2,
        ACT_STOP   = 3'd3
    } ch_act_t;

    // Ratios 0 and 1 cannot be divided and select bypass instead.
    function automatic logic ratio_ok(input logic [WIDTH-1:0] r);
        return (r >= WIDTH'(2));
    endfunction

    // High phase length; odd ratios keep the extra cycle in the low phase.
    function automatic logic [WIDTH-1:0] high_len(input logic [WIDTH-1:0] r);
        return (r >> 1);
    endfunction

    ch_state_t        state_r  [NUM_CH];
    ch_state_t        state_s  [NUM_CH];
    logic [WIDTH-1:0] ratio_r  [NUM_CH];
    logic [WIDTH-1:0] ratio_s  [NUM_CH];
    logic [WIDTH-1:0] cnt_r    [NUM_CH];
    logic [WIDTH-1:0] cnt_s    [NUM_CH];
    logic [WIDTH-1:0] cnt_inc_s[NUM_CH];
    logic [WIDTH-1:0] ratio_in_s[NUM_CH];
    ch_act_t          act_s    [NUM_CH];
    logic [NUM_CH-1:0] div_q_r;
    logic [NUM_CH-1:0] div_q_s;
    logic [NUM_CH-1:0] tick_q_r;
    logic [NUM_CH-1:0] tick_q_s;
    logic [NUM_CH-1:0] div_out_s;
    logic [NUM_CH-1:0] tick_out_s;

    // Per-channel action decision; sync outranks the boundary, which outranks counting.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ratio_in_s[c] = bus.i_div_ratio[c*WIDTH +: WIDTH];
            act_s[c]      = ACT_HOLD;
            case (state_r[c])
                ST_IDLE: begin
                    if (bus.i_clk_en[c]) begin
                        act_s[c] = ACT_RELOAD;
                    end else begin
                        act_s[c] = ACT_HOLD;
                    end
                end
                ST_RUN: begin
                    if (bus.i_sync && bus.i_clk_en[c]) begin
                        act_s[c] = ACT_RELOAD;
                    end else if (cnt_r[c] == (ratio_r[c] - WIDTH'(1))) begin
                        if (bus.i_clk_en[c]) begin
                            act_s[c] = ACT_RELOAD;
                        end else begin
                            act_s[c] = ACT_STOP;
                        end
                    end else begin
                        act_s[c] = ACT_COUNT;
                    end
                end
                ST_BYPASS: begin
                    if (!bus.i_clk_en[c]) begin
                        act_s[c] = ACT_STOP;
                    end else if (ratio_ok(ratio_in_s[c])) begin
                        act_s[c] = ACT_RELOAD;
                    end else begin
                        act_s[c] = ACT_HOLD;
                    end
                end
                default: begin
                    act_s[c] = ACT_STOP;
                end
            endcase
        end
    end

    // Next-state values for each channel from its chosen action.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_inc_s[c] = cnt_r[c] + WIDTH'(1);
            state_s[c]   = state_r[c];
            ratio_s[c]   = ratio_r[c];
            cnt_s[c]     = cnt_r[c];
            div_q_s[c]   = div_q_r[c];
            tick_q_s[c]  = tick_q_r[c];
            case (act_s[c])
                ACT_RELOAD: begin
                    if (ratio_ok(ratio_in_s[c])) begin
                        state_s[c]  = ST_RUN;
                        ratio_s[c]  = ratio_in_s[c];
                        cnt_s[c]    = WIDTH'(0);
                        div_q_s[c]  = 1'b1;
                        tick_q_s[c] = 1'b1;
                    end else begin
                        state_s[c]  = ST_BYPASS;
                        cnt_s[c]    = WIDTH'(0);
                        div_q_s[c]  = 1'b0;
                        tick_q_s[c] = 1'b0;
                    end
                end
                ACT_COUNT: begin
                    cnt_s[c]    = cnt_inc_s[c];
                    tick_q_s[c] = 1'b0;
                    div_q_s[c]  = (cnt_inc_s[c] < high_len(ratio_r[c]));
                end
                ACT_STOP: begin
                    state_s[c]  = ST_IDLE;
                    cnt_s[c]    = WIDTH'(0);
                    div_q_s[c]  = 1'b0;
                    tick_q_s[c] = 1'b0;
                end
                ACT_HOLD: begin
                    state_s[c] = state_r[c];
                end
                default: begin
                    state_s[c]  = ST_IDLE;
                    cnt_s[c]    = WIDTH'(0);
                    div_q_s[c]  = 1'b0;
                    tick_q_s[c] = 1'b0;
                end
            endcase
        end
    end

    // Channel registers with synchronous reset taking priority over everything else.
    always_ff @(posedge i_clk_ref) begin
        if (i_rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_r[c] <= ST_IDLE;
                ratio_r[c] <= WIDTH'(0);
                cnt_r[c]   <= WIDTH'(0);
            end
            div_q_r  <= {NUM_CH{1'b0}};
            tick_q_r <= {NUM_CH{1'b0}};
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_r[c] <= state_s[c];
                ratio_r[c] <= ratio_s[c];
                cnt_r[c]   <= cnt_s[c];
            end
            div_q_r  <= div_q_s;
            tick_q_r <= tick_q_s;
        end
    end

    // Output select; bypass passes the reference clock straight through.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            case (state_r[c])
                ST_RUN: begin
                    div_out_s[c]  = div_q_r[c];
                    tick_out_s[c] = tick_q_r[c];
                end
                ST_BYPASS: begin
                    div_out_s[c]  = i_clk_ref;
                    tick_out_s[c] = 1'b1;
                end
                default: begin
                    div_out_s[c]  = 1'b0;
                    tick_out_s[c] = 1'b0;
                end
            endcase
        end
    end

    assign bus.o_div_clk = div_out_s;
    assign bus.o_tick    = tick_out_s;

endmodule
